// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the controller-to-ALU interface. The controller and
// the execution responder both import this package so they agree on opcode
// encodings.
//   ALU_WIDTH    : default operand/result width
//   alu_op_e     : 3-bit opcode encoding
//   exec_state_e : responder FSM states
//   alu_flags_t  : {O, C, Z, N} flag bundle
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SHR = 3'b101,
    SHL = 3'b110,
    CAS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } exec_state_e;

  typedef struct packed {
    logic O;
    logic C;
    logic Z;
    logic N;
  } alu_flags_t;

  // Shifts are the only multi-cycle operations.
  function automatic logic isShiftOp(input alu_op_e op);
    return (op == SHR) || (op == SHL);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// Combinational WIDTH-bit adder/subtractor shared by ADD, SUB and CAS.
//   i_a, i_b   : operands
//   i_sub      : 1 = compute i_a + ~i_b + 1, 0 = compute i_a + i_b
//   o_sum      : result, mod 2^WIDTH
//   o_carry    : carry out of the MSB (for subtraction, 1 = no borrow)
//   o_overflow : signed overflow
// -----------------------------------------------------------------------------
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_bEff;

  assign w_bEff = i_sub ? ~i_b : i_b;

  // The +1 of two's-complement subtraction enters as the carry-in.
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_bEff} + {{WIDTH{1'b0}}, i_sub};

  // Using the effective B operand makes one overflow rule cover both add and
  // subtract: same input signs but a result sign that differs.
  assign o_overflow = (i_a[WIDTH-1] == w_bEff[WIDTH-1]) &&
                      (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_exec_responder.sv
// -----------------------------------------------------------------------------
// alu_exec_responder
// Execution-side responder: accepts one ALU request per handshake, computes
// y and {O,C,Z,N}, and holds them until the controller takes the response.
// Shifts run one bit per cycle; every other op completes on the accept edge.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (op_code, data_a, data_b)
//   rsp_valid/rsp_ready  : response handshake (y, O, C, Z, N)
//   busy                 : high while shifting or holding a response
// -----------------------------------------------------------------------------
module alu_exec_responder
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] y,
  output logic             O,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             busy
);

  exec_state_e      r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHAMT_W-1:0] r_count;
  logic             r_shiftLeft;
  logic [WIDTH-1:0] r_y;
  alu_flags_t       r_flags;

  logic             w_accept;
  alu_op_e          w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH-1:0] w_resY;
  alu_flags_t       w_resFlags;
  logic [WIDTH-1:0] w_shiftAcc;
  logic             w_shiftOut;

  assign w_op     = alu_op_e'(op_code);
  assign w_shamt  = data_b[SHAMT_W-1:0];
  assign w_sub    = (w_op != ADD);

  assign req_ready = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
  assign w_accept  = req_valid && req_ready;

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a        (data_a),
    .i_b        (data_b),
    .i_sub      (w_sub),
    .o_sum      (w_sum),
    .o_carry    (w_carry),
    .o_overflow (w_ovf)
  );

  // Single-cycle result straight from the request inputs; it is captured only
  // on the accept edge. For shift ops this is the shift-by-zero result.
  always_comb begin
    w_resY     = '0;
    w_resFlags = '0;
    case (w_op)
      ADD, SUB: begin
        w_resY       = w_sum;
        w_resFlags.O = w_ovf;
        w_resFlags.C = w_carry;
      end
      AND:      w_resY = data_a & data_b;
      OR:       w_resY = data_a | data_b;
      XOR:      w_resY = data_a ^ data_b;
      SHR, SHL: w_resY = data_a;
      CAS: begin
        w_resY       = {{(WIDTH-1){1'b0}}, (w_sum == '0)};
        w_resFlags.O = w_ovf;
        w_resFlags.C = w_carry;
        w_resFlags.Z = (w_sum == '0);
        w_resFlags.N = w_sum[WIDTH-1];
      end
      default: w_resY = '0;
    endcase
    // CAS reports the subtraction's Z/N, not those of its 0/1 result.
    if (w_op != CAS) begin
      w_resFlags.Z = (w_resY == '0);
      w_resFlags.N = w_resY[WIDTH-1];
    end
  end

  // One-bit step of the iterative shifter and the bit it drops.
  assign w_shiftAcc = r_shiftLeft ? (r_acc << 1) : (r_acc >> 1);
  assign w_shiftOut = r_shiftLeft ? r_acc[WIDTH-1] : r_acc[0];

  // Responder FSM. y and the flags are written in one assignment each, and
  // only on the edge that enters RESP, so the controller never sees a partial
  // update. Any accept (from IDLE or retiring RESP) takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_shiftLeft <= 1'b0;
      r_y         <= '0;
      r_flags     <= '0;
    end else if (w_accept) begin
      if (isShiftOp(w_op) && (w_shamt != '0)) begin
        r_state     <= SHIFT;
        r_acc       <= data_a;
        r_count     <= w_shamt;
        r_shiftLeft <= (w_op == SHL);
      end else begin
        r_state <= RESP;
        r_y     <= w_resY;
        r_flags <= w_resFlags;
      end
    end else begin
      case (r_state)
        SHIFT: begin
          r_acc   <= w_shiftAcc;
          r_count <= r_count - SHAMT_W'(1);
          if (r_count == SHAMT_W'(1)) begin
            r_state <= RESP;
            r_y     <= w_shiftAcc;
            r_flags <= '{O: 1'b0,
                         C: w_shiftOut,
                         Z: (w_shiftAcc == '0),
                         N: w_shiftAcc[WIDTH-1]};
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state == SHIFT) || (r_state == RESP);
  assign y         = r_y;
  assign O         = r_flags.O;
  assign C         = r_flags.C;
  assign Z         = r_flags.Z;
  assign N         = r_flags.N;

endmodule
